button_event_decoder: RTL
=========================

// Module: button_event_decoder
// PURPOSE
//   Consumes the debounced, clock-synchronous switch level and turns it into
//   discrete one-cycle events: press, release, long-press and auto-repeat.
//   Sits between the switch debouncer and the vga_pong paddle/menu logic.
//   The paddle logic never edge-detects raw levels itself.
// PARAMETERS
//   ACTIVE_LEVEL   1'b1        i_switch level that means "pressed"
//   HOLD_CYCLES    12_500_000  press-to-long-press delay (500 ms @ 25 MHz); must be >= 2
//   REPEAT_CYCLES  2_500_000   auto-repeat period while long-held (100 ms); must be >= 1
//   CNT_W          24          hold/repeat counter width; must hold max(HOLD,REPEAT)-1
// PORTS
//   i_clk        in   1  25 MHz system clock
//   i_rst_n      in   1  synchronous reset, active low
//   i_switch     in   1  debounced switch level, already in i_clk domain
//   o_press      out  1  1-cycle pulse on press
//   o_release    out  1  1-cycle pulse on release
//   o_long       out  1  1-cycle pulse when press held HOLD_CYCLES
//   o_repeat     out  1  1-cycle pulse every REPEAT_CYCLES after o_long
//   o_held       out  1  level: button currently considered pressed
//   o_press_cnt  out  8  running count of presses, wraps 255->0
// BEHAVIOUR
//   - Reset (i_rst_n=0 at posedge): state=IDLE, cnt=0, all outputs 0,
//     o_press_cnt=0. Applies mid-press too; no o_release is emitted on reset.
//     After reset, a switch still held registers as a new press on the
//     first active cycle.
//   - All outputs are registered. Latency is 1 cycle from the sampling edge.
//   - FSM states: IDLE, PRESS, LONG. act = (i_switch == ACTIVE_LEVEL).
//   - IDLE:  act -> PRESS, cnt<=0, o_press=1, o_press_cnt++.
//   - PRESS: !act -> IDLE, o_release=1.
//            act and cnt==HOLD_CYCLES-1 -> LONG, cnt<=0, o_long=1.
//            otherwise cnt++.
//   - LONG:  !act -> IDLE, o_release=1, cnt<=0.
//            act: see CONFIGURATION.
//   - Release and threshold in the same cycle: release wins; no o_long or
//     o_repeat is emitted.
//   - o_held = (state != IDLE). It rises with o_press and falls with o_release.
//   - Timing: o_long fires exactly HOLD_CYCLES cycles after o_press. The
//     first o_repeat fires REPEAT_CYCLES cycles after o_long, then repeats
//     every REPEAT_CYCLES.
//   - Pulses never overlap. A 1-cycle active blip gives o_press, then
//     o_release on the next cycle.
//   - cnt never exceeds max(HOLD_CYCLES, REPEAT_CYCLES)-1; it has no
//     wrap-around hazard.
// CONFIGURATION
//   BTN_EVT_REPEAT_EN defined:
//     In LONG with act: cnt++. When cnt==REPEAT_CYCLES-1: o_repeat=1, cnt<=0.
//   BTN_EVT_REPEAT_EN undefined:
//     o_repeat is tied to 0 and LONG holds cnt at 0. No repeat logic is
//     synthesised; all other behaviour is identical.
// TESTING   (bench params: HOLD_CYCLES=8, REPEAT_CYCLES=4, macro defined)
//   1 Reset with i_switch=0 for 3 cycles -> every output 0, o_press_cnt=0.
//   2 Switch to 1 at cycle 10, held 5 cycles, then 0 -> o_press @11,
//     o_release @16, o_held high for cycles 11-15, no o_long, o_press_cnt=1.
//   3 Switch to 1 at cycle 0, held 30 cycles -> o_press @1, o_long @9,
//     o_repeat @13,17,21,25,29, o_release @31.
//   4 Switch drops at the exact cycle o_long would fire (held 8 cycles) ->
//     o_release only, no o_long.
//   5 Reset mid-LONG -> outputs 0 next cycle, no o_release. Keep switch=1
//     after reset -> o_press one cycle after reset deasserts.
//   6 Issue 257 short presses -> o_press_cnt=1 (wrap).
//     Rebuild without BTN_EVT_REPEAT_EN and rerun case 3 -> o_repeat stays 0.

Source files
------------

// File: rtl/button_event_decoder.sv
// Turns a debounced, synchronous switch level into one-cycle press/release/long/repeat events.
// Auto-repeat is built only when BTN_EVT_REPEAT_EN is defined; otherwise o_repeat is tied low.
module button_event_decoder #(
  parameter logic ACTIVE_LEVEL  = 1'b1,
  parameter int   HOLD_CYCLES   = 12_500_000,
  parameter int   REPEAT_CYCLES = 2_500_000,
  parameter int   CNT_W         = 24
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_switch,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long,
  output logic       o_repeat,
  output logic       o_held,
  output logic [7:0] o_press_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  // Reject parameter sets that would make the hold/repeat thresholds unreachable.
  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("button_event_decoder: HOLD_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               press_reg, press_next;
  logic               release_reg, release_next;
  logic               long_reg, long_next;
  logic [7:0]         press_cnt_reg, press_cnt_next;
  logic               act;

`ifdef BTN_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic repeat_reg, repeat_next;
`endif

  assign act = (i_switch == ACTIVE_LEVEL);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    press_next     = 1'b0;
    release_next   = 1'b0;
    long_next      = 1'b0;
    press_cnt_next = press_cnt_reg;
`ifdef BTN_EVT_REPEAT_EN
    repeat_next    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (act) begin
          state_next     = PRESS;
          cnt_next       = '0;
          press_next     = 1'b1;
          press_cnt_next = press_cnt_reg + 8'd1;
        end
      end
      PRESS: begin
        // Release is checked first so it wins over a coincident hold threshold.
        if (!act) begin
          state_next   = IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next = LONG;
          cnt_next   = '0;
          long_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      LONG: begin
        if (!act) begin
          state_next   = IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
        end else begin
`ifdef BTN_EVT_REPEAT_EN
          if (cnt_reg == REPEAT_LAST) begin
            cnt_next    = '0;
            repeat_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
`else
          cnt_next = '0;
`endif
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
      long_reg      <= 1'b0;
      press_cnt_reg <= 8'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      press_reg     <= press_next;
      release_reg   <= release_next;
      long_reg      <= long_next;
      press_cnt_reg <= press_cnt_next;
    end
  end

`ifdef BTN_EVT_REPEAT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      repeat_reg <= 1'b0;
    end else begin
      repeat_reg <= repeat_next;
    end
  end
  assign o_repeat = repeat_reg;
`else
  assign o_repeat = 1'b0;
`endif

  assign o_press     = press_reg;
  assign o_release   = release_reg;
  assign o_long      = long_reg;
  assign o_held      = (state_reg != IDLE);
  assign o_press_cnt = press_cnt_reg;

endmodule
